// File: rtl/hangman_pkg.sv
// Shared definitions for the Hangman judge and the game status FSM.
package hangman_pkg;

    localparam logic [1:0] ST_START    = 2'd0;
    localparam logic [1:0] ST_INGAME   = 2'd1;
    localparam logic [1:0] ST_WINGAME  = 2'd2;
    localparam logic [1:0] ST_LOSTGAME = 2'd3;

    localparam int unsigned    LETTER_W   = 5;
    localparam logic [4:0]     LETTER_MAX = 5'd25;
    localparam int unsigned    ALPHA_SIZE = 26;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        EVAL,
        DONE
    } judge_state_e;

endpackage

// File: rtl/hangman_letter_match.sv
// Compares one letter code against every position of a packed secret word.
module hangman_letter_match
    import hangman_pkg::*;
#(
    parameter int unsigned WORD_LEN = 4
) (
    input  logic [LETTER_W-1:0]          letter,
    input  logic [LETTER_W*WORD_LEN-1:0] word,
    output logic [WORD_LEN-1:0]          match
);

    always_comb begin
        match = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            match[i] = (word[LETTER_W*i +: LETTER_W] == letter);
        end
    end

endmodule

// File: rtl/hangman_judge.sv
// Hangman guess evaluator: tracks revealed letters and misses for one latched word.
// Optional hint request input is enabled by defining HANGMAN_HINT_EN.
module hangman_judge
    import hangman_pkg::*;
#(
    parameter int unsigned WORD_LEN   = 4,
    parameter int unsigned MAX_MISSES = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    game_state,
    input  logic [LETTER_W*WORD_LEN-1:0]  secret_word,
    input  logic                          guess_valid,
    input  logic [LETTER_W-1:0]           guess_letter,
`ifdef HANGMAN_HINT_EN
    input  logic                          hint_req,
`endif
    output logic                          guess_ready,
    output logic [WORD_LEN-1:0]           reveal_mask,
    output logic [3:0]                    misses,
    output logic                          hit,
    output logic                          repeat_guess,
    output logic                          win_game,
    output logic                          lost_game
);

    judge_state_e                 state_q, state_d;
    logic [LETTER_W*WORD_LEN-1:0] secret_q, secret_d;
    logic [LETTER_W-1:0]          letter_q, letter_d;
    logic                         hint_q, hint_d;
    logic [ALPHA_SIZE-1:0]        bitmap_q, bitmap_d;
    logic [WORD_LEN-1:0]          mask_q, mask_d;
    logic [3:0]                   misses_q, misses_d;
    logic                         hit_q, hit_d;
    logic                         repeat_q, repeat_d;
    logic                         win_q, win_d;
    logic                         lost_q, lost_d;

    logic [WORD_LEN-1:0]          match;
    logic [WORD_LEN-1:0]          mask_next;
    logic [3:0]                   misses_next;
    logic                         seen;

    hangman_letter_match #(
        .WORD_LEN (WORD_LEN)
    ) u_match (
        .letter (letter_q),
        .word   (secret_q),
        .match  (match)
    );

`ifdef HANGMAN_HINT_EN
    logic [LETTER_W-1:0] hint_letter;

    // Descending scan so the lowest unrevealed position wins.
    always_comb begin
        hint_letter = '0;
        for (int i = WORD_LEN - 1; i >= 0; i--) begin
            if (!mask_q[i]) hint_letter = secret_q[LETTER_W*i +: LETTER_W];
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        secret_d    = secret_q;
        letter_d    = letter_q;
        hint_d      = hint_q;
        bitmap_d    = bitmap_q;
        mask_d      = mask_q;
        misses_d    = misses_q;
        hit_d       = 1'b0;
        repeat_d    = 1'b0;
        win_d       = win_q;
        lost_d      = lost_q;
        mask_next   = mask_q | match;
        misses_next = (misses_q >= 4'(MAX_MISSES)) ? misses_q : misses_q + 4'd1;

        seen = 1'b0;
        for (int k = 0; k < ALPHA_SIZE; k++) begin
            if (letter_q == 5'(k)) seen = bitmap_q[k];
        end

        unique case (state_q)
            IDLE: begin
                secret_d = secret_word;
                if (game_state == ST_INGAME) state_d = PLAY;
            end
            PLAY: begin
                if (guess_valid) begin
                    letter_d = guess_letter;
                    hint_d   = 1'b0;
                    state_d  = EVAL;
`ifdef HANGMAN_HINT_EN
                end else if (hint_req) begin
                    letter_d = hint_letter;
                    hint_d   = 1'b1;
                    state_d  = EVAL;
`endif
                end else if (game_state == ST_START) begin
                    state_d = IDLE;
                end
            end
            EVAL: begin
                if (!hint_q && (letter_q > LETTER_MAX || seen)) begin
                    repeat_d = 1'b1;
                    state_d  = PLAY;
                end else begin
                    for (int k = 0; k < ALPHA_SIZE; k++) begin
                        if (letter_q == 5'(k)) bitmap_d[k] = 1'b1;
                    end
                    mask_d = mask_next;
                    if (match == '0 || hint_q) begin
                        misses_d = misses_next;
                    end else begin
                        misses_next = misses_q;
                    end
                    hit_d = (match != '0) && !hint_q;
                    if (&mask_next) begin
                        win_d   = 1'b1;
                        state_d = DONE;
                    end else if (misses_next == 4'(MAX_MISSES)) begin
                        lost_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = PLAY;
                    end
                end
            end
            DONE: begin
                if (game_state == ST_START) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Entering or sitting in IDLE wipes the previous game's progress.
        if (state_d == IDLE) begin
            bitmap_d = '0;
            mask_d   = '0;
            misses_d = '0;
            win_d    = 1'b0;
            lost_d   = 1'b0;
            hint_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            secret_q <= '0;
            letter_q <= '0;
            hint_q   <= 1'b0;
            bitmap_q <= '0;
            mask_q   <= '0;
            misses_q <= '0;
            hit_q    <= 1'b0;
            repeat_q <= 1'b0;
            win_q    <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            secret_q <= secret_d;
            letter_q <= letter_d;
            hint_q   <= hint_d;
            bitmap_q <= bitmap_d;
            mask_q   <= mask_d;
            misses_q <= misses_d;
            hit_q    <= hit_d;
            repeat_q <= repeat_d;
            win_q    <= win_d;
            lost_q   <= lost_d;
        end
    end

    assign guess_ready  = (state_q == PLAY);
    assign reveal_mask  = mask_q;
    assign misses       = misses_q;
    assign hit          = hit_q;
    assign repeat_guess = repeat_q;
    assign win_game     = win_q;
    assign lost_game    = lost_q;

endmodule

// File: tb/tb_hangman_judge.sv
// Directed self-checking bench for hangman_judge (WORD_LEN=4, MAX_MISSES=6).
module tb_hangman_judge;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  game_state;
    logic [19:0] secret_word;
    logic        guess_valid;
    logic [4:0]  guess_letter;
`ifdef HANGMAN_HINT_EN
    logic        hint_req;
`endif
    logic        guess_ready;
    logic [3:0]  reveal_mask;
    logic [3:0]  misses;
    logic        hit;
    logic        repeat_guess;
    logic        win_game;
    logic        lost_game;

    int n_checks = 0;
    int n_pass   = 0;

    logic [19:0] code_w;
    logic [19:0] abba_w;

    always #5 clk = ~clk;

    hangman_judge #(
        .WORD_LEN   (4),
        .MAX_MISSES (6)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .game_state   (game_state),
        .secret_word  (secret_word),
        .guess_valid  (guess_valid),
        .guess_letter (guess_letter),
`ifdef HANGMAN_HINT_EN
        .hint_req     (hint_req),
`endif
        .guess_ready  (guess_ready),
        .reveal_mask  (reveal_mask),
        .misses       (misses),
        .hit          (hit),
        .repeat_guess (repeat_guess),
        .win_game     (win_game),
        .lost_game    (lost_game)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic start_game(input logic [19:0] word);
        game_state  = 2'd0;
        secret_word = word;
        step();
        game_state = 2'd1;
        step();
    endtask

    // Offer a guess in PLAY; returns at T+2 with results visible.
    task automatic guess(input logic [4:0] letter);
        guess_valid  = 1'b1;
        guess_letter = letter;
        step();
        guess_valid = 1'b0;
        step();
    endtask

    initial begin
        code_w       = {5'd4, 5'd3, 5'd14, 5'd2};
        abba_w       = {5'd0, 5'd1, 5'd1, 5'd0};
        reset        = 1'b1;
        game_state   = 2'd0;
        secret_word  = '0;
        guess_valid  = 1'b0;
        guess_letter = '0;
`ifdef HANGMAN_HINT_EN
        hint_req     = 1'b0;
`endif
        step();
        step();
        check("rst_ready", 32'(guess_ready), 32'h0);
        check("rst_mask", 32'(reveal_mask), 32'h0);
        check("rst_misses", 32'(misses), 32'h0);
        check("rst_flags", 32'({hit, repeat_guess, win_game, lost_game}), 32'h0);
        reset = 1'b0;
        step();
        check("idle_ready", 32'(guess_ready), 32'h0);

        // Win path on CODE, with repeats in between.
        start_game(code_w);
        check("play_ready", 32'(guess_ready), 32'h1);
        guess_valid  = 1'b1;
        guess_letter = 5'd14;
        step();
        guess_valid = 1'b0;
        check("eval_ready", 32'(guess_ready), 32'h0);
        check("eval_mask_pending", 32'(reveal_mask), 32'h0);
        step();
        check("g14_hit", 32'(hit), 32'h1);
        check("g14_mask", 32'(reveal_mask), 32'h2);
        check("g14_misses", 32'(misses), 32'h0);
        check("g14_win", 32'(win_game), 32'h0);
        check("g14_ready", 32'(guess_ready), 32'h1);
        step();
        check("hit_pulse", 32'(hit), 32'h0);
        guess(5'd14);
        check("rep14_flag", 32'(repeat_guess), 32'h1);
        check("rep14_misses", 32'(misses), 32'h0);
        check("rep14_mask", 32'(reveal_mask), 32'h2);
        guess(5'd27);
        check("rep27_flag", 32'(repeat_guess), 32'h1);
        check("rep27_misses", 32'(misses), 32'h0);
        check("rep27_mask", 32'(reveal_mask), 32'h2);
        guess(5'd2);
        check("g2_mask", 32'(reveal_mask), 32'h3);
        guess(5'd3);
        check("g3_mask", 32'(reveal_mask), 32'h7);
        guess(5'd4);
        check("win_mask", 32'(reveal_mask), 32'hf);
        check("win_flags", 32'({win_game, lost_game}), 32'h2);
        check("win_ready", 32'(guess_ready), 32'h0);
        game_state = 2'd2;
        step();
        step();
        check("done_hold_ready", 32'(guess_ready), 32'h0);
        check("done_hold_win", 32'(win_game), 32'h1);
        game_state = 2'd0;
        step();
        check("clr_mask", 32'(reveal_mask), 32'h0);
        check("clr_win", 32'(win_game), 32'h0);

        // Lose path: six misses, saturating at the limit.
        start_game(code_w);
        guess(5'd0);
        check("miss1", 32'(misses), 32'h1);
        guess(5'd1);
        check("miss2", 32'(misses), 32'h2);
        guess(5'd5);
        check("miss3", 32'(misses), 32'h3);
        guess(5'd6);
        check("miss4", 32'(misses), 32'h4);
        guess(5'd7);
        check("miss5", 32'(misses), 32'h5);
        check("miss5_lost", 32'(lost_game), 32'h0);
        guess(5'd8);
        check("miss6", 32'(misses), 32'h6);
        check("lose_flags", 32'({win_game, lost_game}), 32'h1);
        check("lose_ready", 32'(guess_ready), 32'h0);
        step();
        check("lose_hold", 32'(misses), 32'h6);
        game_state = 2'd0;
        step();
        check("lose_clr", 32'({misses, lost_game}), 32'h0);

        // Duplicate letters, then abort mid-PLAY.
        start_game(abba_w);
        guess(5'd1);
        check("abba_mask", 32'(reveal_mask), 32'h6);
        check("abba_hit", 32'(hit), 32'h1);
        game_state = 2'd0;
        step();
        check("abort_ready", 32'(guess_ready), 32'h0);
        check("abort_mask", 32'(reveal_mask), 32'h0);
        check("abort_misses", 32'(misses), 32'h0);

        // Reset asserted while the judge is in EVAL.
        start_game(code_w);
        guess(5'd0);
        check("pre_rst_misses", 32'(misses), 32'h1);
        guess_valid  = 1'b1;
        guess_letter = 5'd14;
        step();
        guess_valid = 1'b0;
        reset       = 1'b1;
        step();
        check("evrst_ready", 32'(guess_ready), 32'h0);
        check("evrst_mask", 32'(reveal_mask), 32'h0);
        check("evrst_misses", 32'(misses), 32'h0);
        check("evrst_flags", 32'({hit, repeat_guess, win_game, lost_game}), 32'h0);
        reset = 1'b0;
        step();

`ifdef HANGMAN_HINT_EN
        start_game(code_w);
        hint_req = 1'b1;
        step();
        hint_req = 1'b0;
        step();
        check("hint_mask", 32'(reveal_mask), 32'h1);
        check("hint_misses", 32'(misses), 32'h1);
        check("hint_pulses", 32'({hit, repeat_guess}), 32'h0);
        guess(5'd2);
        check("hint_bitmap_repeat", 32'(repeat_guess), 32'h1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
